// File: rtl/approx_mul_accum_pkg.sv
// approx_acc_pkg: shared types, default widths, bias constant and the
// saturating-add helper for the approximate-multiplier MAC accumulator.
package approx_acc_pkg;

  localparam int PROD_W_DEF = 24;
  localparam int ACC_W_DEF  = 32;

  // Mean truncation error of the mul12u_* family (210944).
  localparam logic [23:0] BIAS_DEF = 24'h033800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Unsigned add of two w-bit operands (w <= 63) clamped to 2^w-1.
  // Result is {overflow, sum}; only the low w bits of sum are meaningful.
  function automatic logic [64:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    s     = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_v}) sat_add = {1'b1, max_v};
    else                   sat_add = {1'b0, s[63:0]};
  endfunction

endpackage

// File: rtl/approx_mul_accum_if.sv
// approx_mul_accum_if: product-in / sum-out valid-ready bus of the accumulator.
// master = product source and result consumer, slave = accumulator.
interface approx_mul_accum_if #(
  parameter int PROD_W = 24,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/approx_mul_accum_sat_add.sv
// approx_sat_add: combinational ACC_W-bit saturating adder. carry reports
// that the result is clamped, either now or because sat_in says it already was.
module approx_sat_add
  import approx_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             sat_in,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [64:0] r;
  logic        unused_hi_bits;

  // Clamp on fresh overflow or when the running value is already pinned.
  always_comb begin
    r     = sat_add(64'(a), 64'(b), ACC_W);
    carry = r[64] | sat_in;
    sum   = carry ? {ACC_W{1'b1}} : r[ACC_W-1:0];
  end

  assign unused_hi_bits = ^r[63:ACC_W];

endmodule

// File: rtl/approx_mul_accum.sv
// approx_mul_accum: sums packets of approximate-multiplier products with
// saturation and emits one result per packet over valid/ready.
// Optional build macro APPROX_ACC_BIAS_EN adds BIAS to every accepted term.
module approx_mul_accum
  import approx_acc_pkg::*;
#(
  parameter int          PROD_W    = PROD_W_DEF,
  parameter int          ACC_W     = ACC_W_DEF,
  parameter int          MAX_TERMS = 256,
  parameter int          CNT_W     = $clog2(MAX_TERMS + 1),
  parameter logic [23:0] BIAS      = BIAS_DEF
) (
  input logic               clk,
  input logic               rst_n,
  approx_mul_accum_if.slave bus
);

  state_t             state, state_nx;
  logic [ACC_W-1:0]   acc, acc_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
  logic               ovf, ovf_nx;
  logic [ACC_W-1:0]   term, sum;
  logic               term_ovf, carry;
  logic               armed, accept, close, load_out;
  logic [ACC_W-1:0]   out_sum_r;
  logic [CNT_W-1:0]   out_count_r;
  logic               out_ovf_r;

`ifdef APPROX_ACC_BIAS_EN
  logic [64:0] term_r;
  logic        unused_term_hi;

  // Bias-compensated term, clamped so a huge product cannot wrap.
  always_comb term_r = sat_add(64'(bus.in_prod), 64'(BIAS), ACC_W);

  assign term           = term_r[ACC_W-1:0];
  assign term_ovf       = term_r[64];
  assign unused_term_hi = ^term_r[63:ACC_W];
`else
  logic [23:0] unused_bias;

  assign term        = ACC_W'(bus.in_prod);
  assign term_ovf    = 1'b0;
  assign unused_bias = BIAS;
`endif

  approx_sat_add #(.ACC_W(ACC_W)) u_add (
    .a      (acc),
    .b      (term),
    .sat_in (ovf | term_ovf),
    .sum    (sum),
    .carry  (carry)
  );

  // in_ready is held low through reset and for the first clock after it.
  assign bus.in_ready = armed && (state != HOLD);
  assign accept       = bus.in_valid & bus.in_ready;
  assign cnt_inc      = cnt + 1'b1;
  assign close        = bus.in_last | (cnt_inc == CNT_W'(MAX_TERMS));

  // Next-state and accumulator update; IDLE relies on acc/cnt/ovf being zero.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    load_out = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_nx = sum;
          cnt_nx = cnt_inc;
          ovf_nx = carry;
          if (close) begin
            state_nx = HOLD;
            load_out = 1'b1;
          end else begin
            state_nx = ACCUM;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nx = IDLE;
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        acc_nx   = '0;
        cnt_nx   = '0;
        ovf_nx   = 1'b0;
      end
    endcase
  end

  // State, accumulator and ready-enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
      armed <= 1'b1;
    end
  end

  // Result registers capture the closing beat and hold until the next close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum_r   <= '0;
      out_count_r <= '0;
      out_ovf_r   <= 1'b0;
    end else if (load_out) begin
      out_sum_r   <= sum;
      out_count_r <= cnt_inc;
      out_ovf_r   <= carry;
    end
  end

  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = out_sum_r;
  assign bus.out_count = out_count_r;
  assign bus.out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_approx_mul_accum.sv
// tb_approx_mul_accum: directed bench for approx_mul_accum (ACC_W=24,
// MAX_TERMS=4). Expected sums include the bias when APPROX_ACC_BIAS_EN is set.
`timescale 1ns/1ps
module tb_approx_mul_accum;

  localparam int PW = 24;
  localparam int AW = 24;
  localparam int MT = 4;
  localparam int CW = $clog2(MT + 1);

`ifdef APPROX_ACC_BIAS_EN
  localparam logic [23:0] B   = 24'd210944;
  localparam logic        BEN = 1'b1;
`else
  localparam logic [23:0] B   = 24'd0;
  localparam logic        BEN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  approx_mul_accum_if #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) bus ();

  approx_mul_accum #(
    .PROD_W(PW), .ACC_W(AW), .MAX_TERMS(MT), .CNT_W(CW), .BIAS(24'h033800)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int              n;
    logic [3:0][23:0] prod;
    logic [23:0]     sum;
    logic [2:0]      cnt;
    logic            ovf;
  } vec_t;

  localparam int NV = 8;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [23:0] p, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    bus.in_last  = l;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%0d required<20", n);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_prod  = '0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{3, {24'd0, 24'd300, 24'd200, 24'd100}, 24'd600 + 3 * B, 3'd3, 1'b0};
    tv[1] = '{1, {24'd0, 24'd0, 24'd0, 24'd5}, 24'd5 + B, 3'd1, 1'b0};
    tv[2] = '{2, {24'd0, 24'd0, 24'd1, 24'hFFFFFF}, 24'hFFFFFF, 3'd2, 1'b1};
    tv[3] = '{1, {24'd0, 24'd0, 24'd0, 24'd7}, 24'd7 + B, 3'd1, 1'b0};
    tv[4] = '{2, {24'd0, 24'd0, 24'd0, 24'd0}, 24'd0 + 2 * B, 3'd2, 1'b0};
    tv[5] = '{4, {24'd4, 24'd3, 24'd2, 24'd1}, 24'd10 + 4 * B, 3'd4, 1'b0};
    tv[6] = '{2, {24'd0, 24'd0, 24'h7FFFFF, 24'h800000}, 24'hFFFFFF, 3'd2, BEN};
    tv[7] = '{3, {24'd0, 24'd0, 24'd5, 24'hFFFFFF}, 24'hFFFFFF, 3'd3, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_ovf", bus.out_ovf, 0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_before_clk", bus.in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_after_clk", bus.in_ready, 1);

    // Table-driven packets, consumer always ready
    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < tv[i].n; k++) begin
        send(tv[i].prod[k], (k == tv[i].n - 1));
        if (k < tv[i].n - 1) chk($sformatf("v%0d_early_valid", i), bus.out_valid, 0);
      end
      chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
      if (bus.out_valid) begin
        chk($sformatf("v%0d_sum", i), bus.out_sum, tv[i].sum);
        chk($sformatf("v%0d_count", i), bus.out_count, tv[i].cnt);
        chk($sformatf("v%0d_ovf", i), bus.out_ovf, tv[i].ovf);
      end
      @(negedge clk);
      chk($sformatf("v%0d_valid_drop", i), bus.out_valid, 0);
    end

    // Back-pressure: result held while out_ready low, beat waits one bubble
    bus.out_ready = 1'b0;
    send(24'd5, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_prod  = 24'd9;
    bus.in_last  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("bp_valid_held", bus.out_valid, 1);
      chk("bp_sum_stable", bus.out_sum, 24'd5 + B);
      chk("bp_in_ready_low", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_bubble_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_next_valid", bus.out_valid, 1);
    chk("bp_next_sum", bus.out_sum, 24'd9 + B);
    chk("bp_next_count", bus.out_count, 1);
    @(negedge clk);
    chk("bp_next_drop", bus.out_valid, 0);

    // Term limit: four beats close the packet without a last flag
    for (int k = 0; k < 3; k++) begin
      send(24'd1, 1'b0);
      chk("tl_early_valid", bus.out_valid, 0);
    end
    send(24'd1, 1'b0);
    chk("tl_valid", bus.out_valid, 1);
    chk("tl_sum", bus.out_sum, 24'd4 + 4 * B);
    chk("tl_count", bus.out_count, 4);
    chk("tl_ovf", bus.out_ovf, 0);
    send(24'd1, 1'b0);
    chk("tl_fifth_open", bus.out_valid, 0);
    send(24'd2, 1'b1);
    chk("tl_second_valid", bus.out_valid, 1);
    chk("tl_second_sum", bus.out_sum, 24'd3 + 2 * B);
    chk("tl_second_count", bus.out_count, 2);
    @(negedge clk);

    // Reset mid-packet: outputs clear at once, partial sum discarded
    send(24'd10, 1'b0);
    send(24'd20, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_sum", bus.out_sum, 0);
    chk("mid_rst_out_count", bus.out_count, 0);
    chk("mid_rst_out_ovf", bus.out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(24'd3, 1'b1);
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_sum", bus.out_sum, 24'd3 + B);
    chk("post_rst_count", bus.out_count, 1);
    chk("post_rst_ovf", bus.out_ovf, 0);
    @(negedge clk);
    chk("post_rst_drop", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_mul_accum.md
Name: approx_mul_accum

Overview:
- Streaming accumulator directly downstream of the 12x12 unsigned approximate multipliers (mul12u_* family).
- Consumes 24-bit products over a valid/ready handshake and sums a packet of products terminated by a last flag or a term limit.
- Emits one saturated sum per packet with a valid/ready handshake.
- Used to run dot-product / MAC workloads for FPGA error and power characterisation of approximate multipliers.

Parameters:
- PROD_W, 24, product input width; matches the 12x12 multiplier output.
- ACC_W, 32, accumulator and output width; must be >= PROD_W.
- MAX_TERMS, 256, maximum products per packet; forced packet close when reached.
- CNT_W, $clog2(MAX_TERMS+1), width of the term counter.
- BIAS, 24'h033800, per-product error-compensation constant (210944). Used only with the optional feature.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, product beat valid.
- in_ready, output, 1, block can accept a beat.
- in_prod, input, PROD_W, unsigned product from the multiplier.
- in_last, input, 1, final product of the packet; sampled with the beat.
- out_valid, output, 1, packet result valid.
- out_ready, input, 1, consumer accepts the result.
- out_sum, output, ACC_W, saturated packet sum.
- out_count, output, CNT_W, number of products accepted in the packet.
- out_ovf, output, 1, saturation occurred during the packet (sticky per packet).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; acc=0; cnt=0; ovf=0; out_valid=0; out_sum=0; out_count=0; out_ovf=0; in_ready=0 while rst_n low, 1 from the first clock after release.
- Beat accepted when in_valid & in_ready. in_ready=1 in IDLE and ACCUM, 0 in HOLD.
- Term value t = zero-extended in_prod to ACC_W (plus BIAS if the feature is enabled).
- Next sum s = acc + t computed at ACC_W+1 bits.
  - If s[ACC_W]=1 or acc is already saturated: acc = 2^ACC_W-1 and ovf=1.
  - Otherwise acc = s[ACC_W-1:0].
- States:
  - IDLE: acc=0, cnt=0, ovf=0. Accepted beat -> ACCUM, or HOLD if it closes the packet.
  - ACCUM: accumulate each accepted beat. Close condition is in_last=1 or cnt+1==MAX_TERMS -> HOLD.
  - HOLD: out_valid=1. out_sum, out_count and out_ovf reflect the closing beat included. On out_ready=1 -> IDLE, out_valid=0 next cycle, internal acc/cnt/ovf cleared.
- Latency: out_valid rises on the clock edge that accepts the closing beat, i.e. visible the cycle after that beat. A single-beat packet gives out_valid one cycle after acceptance.
- Outputs in HOLD stay stable until the handshake completes; out_valid never drops without out_ready.
- Throughput: one beat per cycle inside a packet. One bubble cycle (HOLD->IDLE) between packets minimum.
- in_valid low in ACCUM: hold state, no count change.
- in_prod/in_last are don't-care when in_valid=0.
- cnt never wraps; MAX_TERMS forces close regardless of in_last.
- Saturation is sticky: once saturated, later beats keep acc at max.
- Reset asserted mid-packet or during HOLD: partial sum discarded, all outputs return to reset values immediately, no result emitted.
- out_sum/out_count/out_ovf are registered and hold their last values while out_valid=0. The bench must check them only when out_valid=1.

Optional Feature:
- Macro APPROX_ACC_BIAS_EN.
- Defined: each accepted term is in_prod + BIAS, compensating the mean truncation error of the approximate multiplier. The bias add is in the same cycle as the accumulate; no added latency.
- Undefined: term = in_prod exactly; BIAS parameter is unused.

Decomposition:
- Shared package approx_acc_pkg:
  - state enum {IDLE, ACCUM, HOLD}.
  - default widths PROD_W/ACC_W.
  - BIAS default constant.
  - saturating-add function.
- One sub-module, approx_sat_add: a combinational ACC_W saturating adder with carry-out flag. It is instantiated once and reused by the MAC workloads.

Test Plan:
- Single packet: products 100, 200, 300 (last on 300), out_ready=1 -> out_sum=600, out_count=3, out_ovf=0; out_valid for exactly 1 cycle, one cycle after the 300 beat.
- Back-pressure: packet {5 last}, out_ready=0 for 4 cycles -> out_valid held, out_sum=5 stable, in_ready=0 throughout; release -> next packet accepted after one bubble.
- Term limit: MAX_TERMS=4, stream 1,1,1,1,1 with no last -> first result sum=4, count=4; fifth beat starts a new packet.
- Saturation: ACC_W=24, products 24'hFFFFFF then 1 (last) -> out_sum=24'hFFFFFF, out_ovf=1; the next packet {7 last} gives sum=7, ovf=0.
- Reset mid-packet: accept 10, 20, assert rst_n low -> outputs reset immediately; after release, {3 last} gives out_sum=3, count=1.
- With APPROX_ACC_BIAS_EN: products 0, 0 (last) -> out_sum=421888 (2*BIAS). Without the macro -> out_sum=0.
